// File: rtl/swap_scheduler.sv
// rtl/swap_scheduler.sv - round-robin arbitrated two-phase register bank swap controller
module swap_scheduler #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [AW-1:0]    addr_a0,
  input  logic [AW-1:0]    addr_b0,
  input  logic [AW-1:0]    addr_a1,
  input  logic [AW-1:0]    addr_b1,
  output logic [1:0]       grant,
  output logic [1:0]       done,
  output logic             busy,
  input  logic             load_en,
  input  logic [AW-1:0]    load_addr,
  input  logic [WIDTH-1:0] load_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_A = 3'd1,
    RD_B = 3'd2,
    WR_A = 3'd3,
    WR_B = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] bank [DEPTH];
  logic [WIDTH-1:0] temp_a;
  logic [WIDTH-1:0] temp_b;
  logic [AW-1:0]    sa;
  logic [AW-1:0]    sb;
  logic             last_owner;
  logic             win;

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b1;
    done       = 2'b00;
    // Requester 1 wins alone, or under contention when requester 0 went last.
    win        = req[1] & (~req[0] | ~last_owner);
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (req != 2'b00) state_next = RD_A;
      end
      RD_A: state_next = RD_B;
      RD_B: state_next = WR_A;
      WR_A: state_next = WR_B;
      WR_B: state_next = FIN;
      FIN: begin
        done       = grant;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
      temp_a     <= '0;
      temp_b     <= '0;
      sa         <= '0;
      sb         <= '0;
      grant      <= 2'b00;
      last_owner <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (load_en) bank[load_addr] <= load_data;
          if (req != 2'b00) begin
            sa         <= win ? addr_a1 : addr_a0;
            sb         <= win ? addr_b1 : addr_b0;
            grant      <= win ? 2'b10 : 2'b01;
            last_owner <= win;
          end
        end
        RD_A: temp_a   <= bank[sa];
        RD_B: temp_b   <= bank[sb];
        WR_A: bank[sa] <= temp_b;
        WR_B: bank[sb] <= temp_a;
        FIN:  grant    <= 2'b00;
        default: ;
      endcase
    end
  end

  assign rd_data = bank[rd_addr];

endmodule

// File: tb/tb_swap_scheduler.sv
// tb/tb_swap_scheduler.sv - directed self-checking bench for swap_scheduler
`timescale 1ns/1ps
module tb_swap_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  addr_a0, addr_b0, addr_a1, addr_b1;
  logic [1:0]  grant, done;
  logic        busy;
  logic        load_en;
  logic [1:0]  load_addr;
  logic [15:0] load_data;
  logic [1:0]  rd_addr;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;

  swap_scheduler #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .addr_a0   (addr_a0),
    .addr_b0   (addr_b0),
    .addr_a1   (addr_a1),
    .addr_b1   (addr_b1),
    .grant     (grant),
    .done      (done),
    .busy      (busy),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  always #10 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en   = 1'b0;
  endtask

  task automatic check_bank(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                            input logic [15:0] e2, input logic [15:0] e3);
    logic [15:0] exp [4];
    exp[0] = e0; exp[1] = e1; exp[2] = e2; exp[3] = e3;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 2'(i);
      #1;
      check($sformatf("%s_bank%0d", tag, i), {16'h0, rd_data}, {16'h0, exp[i]});
    end
  endtask

  // Requests from IDLE, then walks the five busy cycles checking grant, done timing and busy length.
  task automatic do_swap(input string tag, input logic [1:0] r, input logic [1:0] exp_grant,
                         input bit drop);
    int busy_cnt = 0;
    int done_at  = 0;
    logic [1:0] done_val = 2'b00;
    req = r;
    tick();
    check({tag, "_grant"}, {30'h0, grant}, {30'h0, exp_grant});
    for (int c = 1; c <= 5; c++) begin
      if (busy) busy_cnt++;
      if (done != 2'b00 && done_at == 0) begin
        done_at  = c;
        done_val = done;
      end
      if (c == 5 && drop) req = 2'b00;
      if (c < 5) tick();
    end
    check({tag, "_done_at"}, done_at, 5);
    check({tag, "_done_val"}, {30'h0, done_val}, {30'h0, exp_grant});
    check({tag, "_busy_cnt"}, busy_cnt, 5);
    tick();
    check({tag, "_idle_busy"}, {31'h0, busy}, 0);
    check({tag, "_idle_grant"}, {30'h0, grant}, 0);
    check({tag, "_idle_done"}, {30'h0, done}, 0);
  endtask

  initial begin
    reset = 1'b1; req = 2'b00; load_en = 1'b0; load_addr = '0; load_data = '0;
    addr_a0 = '0; addr_b0 = '0; addr_a1 = '0; addr_b1 = '0; rd_addr = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_grant", {30'h0, grant}, 0);
    check("rst_done", {30'h0, done}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check_bank("rst", 16'h0, 16'h0, 16'h0, 16'h0);

    load(2'd0, 16'h1234);
    load(2'd3, 16'hABCD);
    addr_a0 = 2'd0; addr_b0 = 2'd3;
    do_swap("single", 2'b01, 2'b01, 1);
    check_bank("single", 16'hABCD, 16'h0, 16'h0, 16'h1234);

    load(2'd2, 16'h5A5A);
    addr_a0 = 2'd2; addr_b0 = 2'd2;
    do_swap("same", 2'b01, 2'b01, 1);
    check_bank("same", 16'hABCD, 16'h0, 16'h5A5A, 16'h1234);

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    load(2'd0, 16'h0000);
    load(2'd1, 16'h0011);
    load(2'd2, 16'h0022);
    load(2'd3, 16'h0033);
    addr_a0 = 2'd1; addr_b0 = 2'd2; addr_a1 = 2'd2; addr_b1 = 2'd3;
    do_swap("rr1", 2'b11, 2'b01, 0);
    do_swap("rr2", 2'b11, 2'b10, 0);
    check_bank("rr2", 16'h0, 16'h0022, 16'h0033, 16'h0011);
    do_swap("rr3", 2'b11, 2'b01, 1);
    check_bank("rr3", 16'h0, 16'h0033, 16'h0022, 16'h0011);

    addr_a0 = 2'd0; addr_b0 = 2'd3;
    req = 2'b01;
    tick();
    tick();
    check("blk_busy", {31'h0, busy}, 1);
    load_en = 1'b1; load_addr = 2'd1; load_data = 16'hFFFF;
    tick();
    load_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) req = 2'b00;
      tick();
    end
    check("blk_idle", {31'h0, busy}, 0);
    check_bank("blk", 16'h0011, 16'h0033, 16'h0022, 16'h0000);
    load(2'd1, 16'hFFFF);
    check_bank("idle_load", 16'h0011, 16'hFFFF, 16'h0022, 16'h0000);

    addr_a0 = 2'd1; addr_b0 = 2'd2;
    req = 2'b01;
    tick();
    tick();
    tick();
    reset = 1'b1;
    req   = 2'b00;
    tick();
    reset = 1'b0;
    check("mid_grant", {30'h0, grant}, 0);
    check("mid_busy", {31'h0, busy}, 0);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("mid_done%0d", c), {30'h0, done}, 0);
      tick();
    end
    check_bank("mid", 16'h0, 16'h0, 16'h0, 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/swap_scheduler.md
Name: swap_scheduler

Overview:
- Controller for a small register bank that swaps two entries without a race, using an explicit read phase into temporaries followed by a write phase.
- Two requesters share the single bank read port and single write port; a round-robin arbiter picks one swap job at a time.
- Also provides a load port for initialisation and an asynchronous observe port for monitors and benches.

Parameters:
WIDTH, 16, data width of each bank entry and of temp_a/temp_b
DEPTH, 4, number of bank entries (power of two)
AW, 2, address width, equal to log2(DEPTH)

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
req  input  2  per-requester swap request; hold high until matching done
addr_a0  input  AW  requester 0 first swap address
addr_b0  input  AW  requester 0 second swap address
addr_a1  input  AW  requester 1 first swap address
addr_b1  input  AW  requester 1 second swap address
grant  output  2  one-hot current owner; 0 when idle
done  output  2  one-cycle pulse to the owner when its swap completes
busy  output  1  high in any state other than IDLE
load_en  input  1  write load_data to load_addr; honoured only in IDLE
load_addr  input  AW  load address
load_data  input  WIDTH  load data
rd_addr  input  AW  observe address
rd_data  output  WIDTH  combinational bank[rd_addr]

Behaviour:
- Reset (sync, active-high):
  - state=IDLE; all bank entries=0; temp_a=temp_b=0.
  - grant=0, done=0, busy=0.
  - last_owner=1, so requester 0 wins the first contention.
  - Reset mid-swap aborts the swap: no done pulse, and any partial writes are overwritten by the bank clear.
- FSM, one cycle per state: IDLE -> RD_A -> RD_B -> WR_A -> WR_B -> FIN -> IDLE.
- IDLE:
  - If req!=0 at the edge: latch the winner's addresses into sa/sb, set grant one-hot, update last_owner, go to RD_A.
  - Arbitration: a single requester wins outright. If req=2'b11, the winner is the requester != last_owner.
- RD_A: temp_a <= bank[sa].
- RD_B: temp_b <= bank[sb].
- WR_A: bank[sa] <= temp_b.
- WR_B: bank[sb] <= temp_a.
- FIN: done[owner]=1 for exactly this cycle; grant still held. Next state is IDLE, where grant=0 and done=0.
- Latency: grant visible 1 cycle after req sampled in IDLE. done is high in the 5th cycle after grant rises. Minimum spacing between successive grants is 6 cycles; IDLE lasts at least 1 cycle.
- Addresses are sampled only at grant time; changes to addr_*/req during the swap are ignored.
- A request dropped mid-swap still completes and still pulses done.
- sa==sb: the full sequence runs and the entry value is unchanged.
- load_en:
  - In IDLE: writes bank at the edge. A simultaneous req is also granted; its RD_A sees the loaded value.
  - In any other state: ignored, no write.
- rd_data is combinational. A written value appears on rd_data the cycle after the write edge.
- No arithmetic; all data paths are WIDTH bits, and addresses wrap naturally modulo DEPTH.

Test Plan:
- Reset then idle:
  - Stimulus: reset high 2 cycles, then low.
  - Required: grant=0, done=0, busy=0, rd_data=0 for every address.
- Single swap:
  - Stimulus: load bank[0]=16'h1234, bank[3]=16'hABCD; then req=2'b01 with addr_a0=0, addr_b0=3.
  - Required: grant=01 next cycle; done[0] pulses 5 cycles later; afterwards bank[0]=ABCD, bank[3]=1234; busy high exactly 5 cycles.
- Contention and round-robin:
  - Stimulus: req=2'b11 held after reset. Requester 0 swaps (1,2); requester 1 swaps (2,3). Initial bank = 0,0x11,0x22,0x33.
  - Required: grant sequence 01 then 10 then 01, alternating. After the first two swaps the bank is 0,0x22,0x33,0x11.
- Same-address swap:
  - Stimulus: addr_a0=addr_b0=2, bank[2]=16'h5A5A.
  - Required: done pulses after the full 5-cycle sequence; bank[2] stays 5A5A.
- Load blocked while busy:
  - Stimulus: load_en=1 with load_addr=1, load_data=16'hFFFF during RD_B.
  - Required: bank[1] unchanged. The same load issued in IDLE lands.
- Reset mid-swap:
  - Stimulus: assert reset during WR_A.
  - Required: next cycle state=IDLE, grant=0, no done pulse, all entries 0.
